// File: rtl/t2d_nrzi_rx_if.sv
// Byte output port of the toggle-to-data receiver.
// The master drives byte_out/byte_valid. The slave (downstream) drives out_ready.
interface t2d_nrzi_rx_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       out_ready;

    modport master (
        output byte_out,
        output byte_valid,
        input  out_ready
    );

    modport slave (
        input  byte_out,
        input  byte_valid,
        output out_ready
    );
endinterface : t2d_nrzi_rx_if

// File: rtl/t2d_nrzi_rx.sv
// Toggle-to-data (NRZI) serial receiver.
// A line toggle decodes as 1 and a steady level decodes as 0.
// The receiver hunts for the sync byte in a sliding window, then assembles
// FRAME_LEN payload bytes MSB-first and offers each byte on a valid/ready port.
// A byte that completes while the port still holds an unconsumed byte is
// dropped, and the sticky overrun flag is set.
module t2d_nrzi_rx #(
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter int unsigned FRAME_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               bit_en,
    t2d_nrzi_rx_if.master      bus,
    output logic               sync_found,
    output logic               overrun,
    output logic               in_frame
);

    typedef enum logic [1:0] {
        HUNT = 2'b00,
        RECV = 2'b01
    } state_t;

    localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);

    // Append one decoded bit at the LSB end. The stream is MSB-first.
    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
        return {cur[6:0], b};
    endfunction

    state_t     state_r;
    logic       prev_level_r;
    logic [7:0] shreg_r;
    logic [7:0] asm_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] byte_cnt_r;
    logic [7:0] byte_out_r;
    logic       byte_valid_r;
    logic       sync_found_r;
    logic       overrun_r;
    logic       in_frame_r;

    logic       bit_s;
    logic [7:0] shreg_next_s;
    logic [7:0] asm_next_s;
    logic       consume_s;
    logic       last_bit_s;
    logic       frame_end_s;

    // Decode the current line level and precompute next-state helpers.
    always_comb begin
        bit_s        = din ^ prev_level_r;
        shreg_next_s = shift_in(shreg_r, bit_s);
        asm_next_s   = shift_in(asm_r, bit_s);
        consume_s    = byte_valid_r & bus.out_ready;
        last_bit_s   = (bit_cnt_r == 3'd7);
        frame_end_s  = ((byte_cnt_r + 8'd1) == FRAME_LEN_C);
    end

    // Track the previous line level. It moves only on a bit strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_level_r <= 1'b0;
        end else if (bit_en) begin
            prev_level_r <= din;
        end else begin
            prev_level_r <= prev_level_r;
        end
    end

    // Run the sync hunt / frame receive FSM, the byte assembly and the output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= HUNT;
            shreg_r      <= 8'h00;
            asm_r        <= 8'h00;
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= 8'd0;
            byte_out_r   <= 8'h00;
            byte_valid_r <= 1'b0;
            sync_found_r <= 1'b0;
            overrun_r    <= 1'b0;
            in_frame_r   <= 1'b0;
        end else begin
            sync_found_r <= 1'b0;

            // Consumption frees the port. A byte completing this cycle may refill it below.
            if (consume_s) begin
                byte_valid_r <= 1'b0;
            end

            case (state_r)
                HUNT: begin
                    in_frame_r <= 1'b0;
                    if (bit_en) begin
                        shreg_r <= shreg_next_s;
                        if (shreg_next_s == SYNC) begin
                            state_r      <= RECV;
                            sync_found_r <= 1'b1;
                            in_frame_r   <= 1'b1;
                            bit_cnt_r    <= 3'd0;
                            byte_cnt_r   <= 8'd0;
                        end
                    end
                end

                RECV: begin
                    if (bit_en) begin
                        asm_r     <= asm_next_s;
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (last_bit_s) begin
                            // A full port that is not being drained cannot take the byte.
                            if (!byte_valid_r || consume_s) begin
                                byte_out_r   <= asm_next_s;
                                byte_valid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                            byte_cnt_r <= byte_cnt_r + 8'd1;
                            if (frame_end_s) begin
                                state_r    <= HUNT;
                                shreg_r    <= 8'h00;
                                in_frame_r <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_r    <= HUNT;
                    shreg_r    <= 8'h00;
                    in_frame_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_out   = byte_out_r;
    assign bus.byte_valid = byte_valid_r;
    assign sync_found     = sync_found_r;
    assign overrun        = overrun_r;
    assign in_frame       = in_frame_r;

endmodule : t2d_nrzi_rx

// File: tb/tb_t2d_nrzi_rx.sv
// Self-checking bench for t2d_nrzi_rx.
// Expected payload bytes are pushed to a scoreboard queue as stimulus is driven.
// A negedge monitor pops and compares each byte at the handshake.
module tb_t2d_nrzi_rx;

    localparam logic [7:0] SYNC_C = 8'hA5;

    logic clk;
    logic rst_n;
    logic din;
    logic bit_en;
    logic sync_found;
    logic overrun;
    logic in_frame;

    t2d_nrzi_rx_if bus ();

    t2d_nrzi_rx #(.SYNC(8'hA5), .FRAME_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .bit_en     (bit_en),
        .bus        (bus),
        .sync_found (sync_found),
        .overrun    (overrun),
        .in_frame   (in_frame)
    );

    int         checks;
    int         errors;
    int         sync_cnt;
    logic       line;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [31:0] pay;
        logic        ready;
        logic        exp_ovr;
    } frame_vec_t;

    frame_vec_t tbl [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a byte transfers at the next posedge whenever valid & ready are high here.
    always @(negedge clk) begin
        if (sync_found === 1'b1) sync_cnt++;
        if (rst_n === 1'b1 && bus.byte_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'h0, bus.byte_out}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_byte", {24'h0, bus.byte_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // All drives happen 2 time units after a posedge.
    task automatic do_reset();
        rst_n = 1'b0; bit_en = 1'b0; din = 1'b0; bus.out_ready = 1'b0; line = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        if (b) line = ~line;
        din = line;
        bit_en = 1'b1;
        @(posedge clk);
        #2 bit_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.byte_valid) && n < 30) begin
            idle(1);
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_valid_low", {31'h0, bus.byte_valid}, 32'h0);
    endtask

    initial begin
        logic [7:0] pb;
        int         base;
        checks = 0; errors = 0; sync_cnt = 0;
        exp_q.delete();

        tbl[0] = '{pay: 32'h3CA5_FF00, ready: 1'b1, exp_ovr: 1'b0};
        tbl[1] = '{pay: 32'h0000_0000, ready: 1'b1, exp_ovr: 1'b0};
        tbl[2] = '{pay: 32'hFFFF_FFFF, ready: 1'b1, exp_ovr: 1'b0};
        tbl[3] = '{pay: 32'h5AC3_817E, ready: 1'b1, exp_ovr: 1'b0};
        tbl[4] = '{pay: 32'h3CA5_FF00, ready: 1'b0, exp_ovr: 1'b1};

        do_reset();
        chk("rst_byte_out", {24'h0, bus.byte_out}, 32'h0);
        chk("rst_valid", {31'h0, bus.byte_valid}, 32'h0);
        chk("rst_sync", {31'h0, sync_found}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_in_frame", {31'h0, in_frame}, 32'h0);

        // Table-driven frames.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            base = sync_cnt;
            send_byte(SYNC_C);
            chk("tbl_sync_pulse", {31'h0, sync_found}, 32'h1);
            chk("tbl_in_frame", {31'h0, in_frame}, 32'h1);
            chk("tbl_valid_after_sync", {31'h0, bus.byte_valid}, 32'h0);
            idle(1);
            chk("tbl_sync_one_cycle", {31'h0, sync_found}, 32'h0);
            bus.out_ready = tbl[t].ready;
            for (int k = 0; k < 4; k++) begin
                pb = tbl[t].pay[31 - 8*k -: 8];
                if (tbl[t].ready || k == 0) exp_q.push_back(pb);
                send_byte(pb);
                chk("tbl_valid", {31'h0, bus.byte_valid}, 32'h1);
                chk("tbl_byte_out", {24'h0, bus.byte_out},
                    {24'h0, (tbl[t].ready ? pb : tbl[t].pay[31:24])});
                chk("tbl_overrun", {31'h0, overrun}, {31'h0, (tbl[t].exp_ovr && k >= 1)});
                chk("tbl_in_frame_k", {31'h0, in_frame}, {31'h0, (k < 3)});
            end
            drain();
            chk("tbl_no_resync", sync_cnt - base, 1);
            chk("tbl_overrun_sticky", {31'h0, overrun}, {31'h0, tbl[t].exp_ovr});
        end

        // Consumption in the same cycle as completion is a load, not an overrun.
        do_reset();
        send_byte(SYNC_C);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        for (int i = 7; i >= 1; i--) send_bit(SYNC_C[i]);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        bus.out_ready = 1'b1;
        send_bit(SYNC_C[0]);
        chk("same_cycle_valid", {31'h0, bus.byte_valid}, 32'h1);
        chk("same_cycle_byte", {24'h0, bus.byte_out}, 32'hA5);
        chk("same_cycle_overrun", {31'h0, overrun}, 32'h0);
        send_byte(8'hFF);
        send_byte(8'h00);
        drain();
        chk("same_cycle_overrun_end", {31'h0, overrun}, 32'h0);

        // Noise then SYNC, with idle gaps between strobes.
        do_reset();
        base = sync_cnt;
        send_bit(1'b1); idle($urandom_range(2, 5));
        send_bit(1'b1); idle($urandom_range(2, 5));
        send_bit(1'b0); idle($urandom_range(2, 5));
        for (int i = 7; i >= 1; i--) begin
            send_bit(SYNC_C[i]);
            idle($urandom_range(2, 5));
        end
        chk("noise_no_early_sync", sync_cnt - base, 0);
        chk("noise_not_in_frame", {31'h0, in_frame}, 32'h0);
        send_bit(SYNC_C[0]);
        chk("noise_sync_pulse", {31'h0, sync_found}, 32'h1);
        chk("noise_in_frame", {31'h0, in_frame}, 32'h1);
        idle($urandom_range(2, 5));
        chk("noise_idle_in_frame", {31'h0, in_frame}, 32'h1);
        chk("noise_idle_sync_low", {31'h0, sync_found}, 32'h0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pb = 8'h96 ^ 8'(k * 8'h11);
            exp_q.push_back(pb);
            for (int i = 7; i >= 0; i--) begin
                send_bit(pb[i]);
                idle($urandom_range(2, 5));
            end
        end
        drain();
        chk("noise_frame_done", {31'h0, in_frame}, 32'h0);

        // Reset mid-frame discards state, and payload without SYNC yields nothing.
        do_reset();
        send_byte(SYNC_C);
        for (int i = 7; i >= 4; i--) send_bit(1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        chk("midrst_valid", {31'h0, bus.byte_valid}, 32'h0);
        chk("midrst_byte_out", {24'h0, bus.byte_out}, 32'h0);
        chk("midrst_in_frame", {31'h0, in_frame}, 32'h0);
        chk("midrst_overrun", {31'h0, overrun}, 32'h0);
        chk("midrst_sync", {31'h0, sync_found}, 32'h0);
        rst_n = 1'b1;
        line = 1'b0;
        base = sync_cnt;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) send_byte(8'h3C);
        idle(3);
        chk("midrst_no_valid", {31'h0, bus.byte_valid}, 32'h0);
        chk("midrst_no_sync", sync_cnt - base, 0);
        chk("midrst_no_frame", {31'h0, in_frame}, 32'h0);
        chk("midrst_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_t2d_nrzi_rx

// File: doc/t2d_nrzi_rx.md
# t2d_nrzi_rx

Toggle-to-data serial receiver. It recovers data bits from a line where a logic 1 is sent as a level toggle and a logic 0 as no toggle (NRZI, T-flip-flop semantics). It hunts for a sync byte, assembles a fixed-length frame of bytes, and presents each byte on a valid/ready output port. It is the receive end for our toggle-encoded serial links and is the counterpart of the D-to-T conversion logic.

## Interface
- SYNC, 8'hA5, sync byte searched for in the decoded bit stream (MSB-first).
- FRAME_LEN, 4, payload bytes per frame after sync; legal range 1..255.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- din  input  1  encoded line level; sampled only when bit_en=1.
- bit_en  input  1  one-cycle bit strobe; at most one bit per strobe.
- out_ready  input  1  downstream accepts byte_out when high with byte_valid.
- byte_out  output  8  received payload byte; stable while byte_valid=1.
- byte_valid  output  1  byte_out holds an unconsumed byte.
- sync_found  output  1  one-cycle pulse when SYNC is detected.
- overrun  output  1  sticky; a completed byte was dropped because the output was still full.
- in_frame  output  1  high while in state RECV.

## Operation
- Decode on each bit_en: bit = din ^ prev_level; prev_level <= din. Update prev_level only on bit_en.
- State HUNT:
  - shreg <= {shreg[6:0], bit}.
  - If the next shreg value equals SYNC, go to RECV, pulse sync_found, and clear bit_cnt and byte_cnt.
- State RECV:
  - Shift bits MSB-first into the assembly register; bit_cnt counts 0..7.
  - On the 8th bit, the byte is complete. If the output is empty, or is being consumed this same cycle (byte_valid & out_ready), load byte_out and set byte_valid.
  - Otherwise drop the byte and set overrun.
  - byte_cnt increments on every completed byte, dropped or not.
  - When byte_cnt reaches FRAME_LEN, return to HUNT with shreg cleared to 8'h00.
- Output handshake:
  - byte_valid clears on the cycle after byte_valid & out_ready, unless a new byte loads in that same cycle. In that case byte_valid stays 1 and byte_out takes the new value.
  - A new byte completing in the same cycle as consumption is a legal load, not an overrun.
- overrun clears only on reset.
- The FSM has two states only (HUNT, RECV). Unused encodings return to HUNT.

## Timing
- Reset (rst_n=0 at a posedge) forces:
  - state=HUNT, prev_level=0, shreg=0, bit_cnt=0, byte_cnt=0.
  - byte_out=8'h00, byte_valid=0, sync_found=0, overrun=0, in_frame=0.
- Reset mid-frame discards the partial byte and any pending output byte. A fresh SYNC is required afterwards.
- sync_found asserts in the cycle after the posedge that samples the last sync bit, for exactly one cycle. in_frame rises in the same cycle.
- byte_valid rises in the cycle after the posedge sampling the 8th payload bit (latency 1 clk from the final strobe).
- Cycles with bit_en=0 leave all decode state unchanged; the handshake still operates.
- The sync search uses a sliding window. SYNC bits overlapping prior noise are detected, and no bit alignment is assumed.
- Payload bytes that equal SYNC inside RECV are data and are not re-detected as sync.
- din is assumed already synchronised to clk.

## Test plan
- Reset, then levels 1,1,0,0,0,1,1,0 on consecutive strobes (decodes to 8'hA5) -> sync_found pulses once; in_frame=1; byte_valid=0.
- After sync, send payload 8'h3C,8'hA5,8'hFF,8'h00 with out_ready=1 -> byte_valid pulses four times with exactly those values; in_frame drops after the 4th byte; the 8'hA5 payload produces no sync_found.
- Same frame with out_ready=0 throughout -> byte_out holds 8'h3C; overrun=1 after the 2nd byte completes; later bytes are not visible.
- Raise out_ready in the same cycle the 2nd byte completes -> 8'h3C is consumed, 8'hA5 loads, byte_valid stays 1, overrun stays 0.
- Noise bits 1,1,0 then SYNC, with 2-5 idle cycles between strobes -> sync is detected at the correct bit, and idle cycles change nothing.
- Assert rst_n=0 for one cycle after 4 payload bits -> all outputs return to reset values; a following payload without SYNC yields no byte_valid.
